// File: rtl/operand_loader_if.sv
// Byte-stream input and operand-pair output of the operand loader.
// The slave modport is the loader itself; master is the surrounding logic.
interface operand_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_valid;
  logic       op_ready;

  modport master (
    output in_data, in_valid, op_ready,
    input  in_ready, op_a, op_b, op_valid
  );

  modport slave (
    input  in_data, in_valid, op_ready,
    output in_ready, op_a, op_b, op_valid
  );
endinterface

// File: rtl/operand_loader.sv
// Collects operand A then operand B from a byte stream and presents them as a pair.
// Abandons a half-received pair if B does not arrive within TIMEOUT cycles.
module operand_loader #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clr_err,
  operand_loader_if.slave  bus,
  output logic [7:0]       pair_count,
  output logic             timeout_flag
);

  typedef enum logic [1:0] {WAIT_A, WAIT_B, PRESENT} state_t;

  localparam logic [7:0] TIMER_LAST = TIMEOUT - 8'd1;

  state_t     state_reg;
  logic [7:0] timer_reg;
  logic [7:0] op_a_reg;
  logic [7:0] op_b_reg;
  logic       op_valid_reg;
  logic [7:0] pair_count_reg;
  logic       timeout_flag_reg;
  logic       xfer;

  assign bus.in_ready = ena && rst_n && (state_reg != PRESENT);
  assign xfer         = bus.in_valid && bus.in_ready;

  assign bus.op_a     = op_a_reg;
  assign bus.op_b     = op_b_reg;
  assign bus.op_valid = op_valid_reg;
  assign pair_count   = pair_count_reg;
  assign timeout_flag = timeout_flag_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= WAIT_A;
      timer_reg        <= 8'd0;
      op_a_reg         <= 8'd0;
      op_b_reg         <= 8'd0;
      op_valid_reg     <= 1'b0;
      pair_count_reg   <= 8'd0;
      timeout_flag_reg <= 1'b0;
    end else if (ena) begin
      // A timeout set further down overrides this clear on the same edge.
      if (clr_err) begin
        timeout_flag_reg <= 1'b0;
      end
      case (state_reg)
        WAIT_A: begin
          if (xfer) begin
            op_a_reg  <= bus.in_data;
            timer_reg <= 8'd0;
            state_reg <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (xfer) begin
            op_b_reg     <= bus.in_data;
            op_valid_reg <= 1'b1;
            state_reg    <= PRESENT;
          end else if (timer_reg == TIMER_LAST) begin
            timer_reg        <= 8'd0;
            timeout_flag_reg <= 1'b1;
            state_reg        <= WAIT_A;
          end else begin
            timer_reg <= timer_reg + 8'd1;
          end
        end
        PRESENT: begin
          if (bus.op_ready) begin
            op_valid_reg   <= 1'b0;
            pair_count_reg <= pair_count_reg + 8'd1;
            state_reg      <= WAIT_A;
          end
        end
        default: begin
          state_reg <= WAIT_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: directed vector table, corner-case
// sequences and randomized traffic against a pair-level reference model.
module tb_operand_loader;

  localparam logic [7:0] TO = 8'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] pair_count;
  logic       timeout_flag;

  operand_loader_if bus ();

  operand_loader #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .clr_err      (clr_err),
    .bus          (bus),
    .pair_count   (pair_count),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: how many bytes of the current pair are held, and how
  // many idle cycles have elapsed while waiting for the second byte.
  int         m_bytes;
  int         m_idle;
  logic [7:0] m_a;
  logic [7:0] m_b;
  int         m_pairs;
  bit         m_flag;

  task automatic model_reset();
    m_bytes = 0;
    m_idle  = 0;
    m_a     = 8'd0;
    m_b     = 8'd0;
    m_pairs = 0;
    m_flag  = 1'b0;
  endtask

  task automatic model_edge();
    bit abandoned;
    abandoned = 1'b0;
    if (!rst_n || !ena) return;
    if (m_bytes == 2) begin
      if (bus.op_ready) begin
        m_pairs = (m_pairs + 1) % 256;
        m_bytes = 0;
      end
    end else if (bus.in_valid) begin
      if (m_bytes == 0) begin
        m_a    = bus.in_data;
        m_idle = 0;
      end else begin
        m_b = bus.in_data;
      end
      m_bytes = m_bytes + 1;
    end else if (m_bytes == 1) begin
      m_idle = m_idle + 1;
      if (m_idle == int'(TO)) begin
        abandoned = 1'b1;
        m_bytes   = 0;
      end
    end
    if (abandoned) m_flag = 1'b1;
    else if (clr_err) m_flag = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'(ena && rst_n && (m_bytes != 2)));
    check({tag, " op_valid"}, 32'(bus.op_valid), 32'(m_bytes == 2));
    check({tag, " op_a"}, 32'(bus.op_a), 32'(m_a));
    check({tag, " op_b"}, 32'(bus.op_b), 32'(m_b));
    check({tag, " pair_count"}, 32'(pair_count), 32'(m_pairs));
    check({tag, " timeout_flag"}, 32'(timeout_flag), 32'(m_flag));
  endtask

  task automatic drive(input bit e, input bit v, input logic [7:0] d, input bit r, input bit c);
    ena          = e;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.op_ready = r;
    clr_err      = c;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send(input logic [7:0] d, input string tag);
    drive(1'b1, 1'b1, d, 1'b0, 1'b0);
    step();
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      step();
      check_all(tag);
    end
  endtask

  task automatic consume(input string tag);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    step();
    check_all(tag);
  endtask

  typedef struct {
    bit         ena;
    bit         valid;
    logic [7:0] data;
    bit         rdy;
    bit         e_ready;
    bit         e_valid;
    logic [7:0] e_a;
    logic [7:0] e_b;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 8'h85, 1'b0, 1'b1, 1'b0, 8'h85, 8'h00, 8'd0};
    tbl[1] = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h85, 8'h3C, 8'd0};
    tbl[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h85, 8'h3C, 8'd1};
    tbl[3] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h85, 8'h3C, 8'd1};
    tbl[4] = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h01, 8'h3C, 8'd1};
    tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 8'h3C, 8'd1};
    tbl[6] = '{1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 8'h02, 8'd1};
    tbl[7] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'h01, 8'h02, 8'd1};
    tbl[8] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 8'h02, 8'd2};

    model_reset();
    // Reset held with traffic offered: nothing may be accepted.
    drive(1'b1, 1'b1, 8'hAB, 1'b1, 1'b0);
    step();
    step();
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check("reset op_valid", 32'(bus.op_valid), 32'd0);
    check("reset op_a", 32'(bus.op_a), 32'd0);
    check("reset op_b", 32'(bus.op_b), 32'd0);
    check("reset pair_count", 32'(pair_count), 32'd0);
    check("reset timeout_flag", 32'(timeout_flag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].ena, tbl[i].valid, tbl[i].data, tbl[i].rdy, 1'b0);
      step();
      $display("vec %0d: ena=%0b valid=%0b data=%02h rdy=%0b -> ready=%0b valid=%0b a=%02h b=%02h cnt=%0d",
               i, tbl[i].ena, tbl[i].valid, tbl[i].data, tbl[i].rdy,
               bus.in_ready, bus.op_valid, bus.op_a, bus.op_b, pair_count);
      check($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_ready));
      check($sformatf("vec%0d op_valid", i), 32'(bus.op_valid), 32'(tbl[i].e_valid));
      check($sformatf("vec%0d op_a", i), 32'(bus.op_a), 32'(tbl[i].e_a));
      check($sformatf("vec%0d op_b", i), 32'(bus.op_b), 32'(tbl[i].e_b));
      check($sformatf("vec%0d pair_count", i), 32'(pair_count), 32'(tbl[i].e_cnt));
      check($sformatf("vec%0d timeout_flag", i), 32'(timeout_flag), 32'd0);
    end

    // Backpressure: pair held for 10 cycles while upstream keeps offering.
    send(8'hA5, "bp a");
    send(8'h5A, "bp b");
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
      step();
      check_all("bp hold");
    end
    check("bp held op_b", 32'(bus.op_b), 32'h5A);
    consume("bp consume");
    check("bp count", 32'(pair_count), 32'd3);
    consume("bp stray ready");
    $display("backpressure: pair_count=%0d", pair_count);

    // Timeout after exactly TO idle cycles in WAIT_B.
    send(8'h11, "to a");
    idle(3, "to wait");
    check("to not yet", 32'(timeout_flag), 32'd0);
    idle(1, "to fire");
    check("to flag", 32'(timeout_flag), 32'd1);
    check("to op_valid", 32'(bus.op_valid), 32'd0);
    check("to stale op_a", 32'(bus.op_a), 32'h11);
    send(8'h22, "to next is a");
    check("to restart op_a", 32'(bus.op_a), 32'h22);
    check("to restart op_valid", 32'(bus.op_valid), 32'd0);
    idle(3, "to2 wait");
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    check_all("to2 fire with clr");
    check("clr vs timeout", 32'(timeout_flag), 32'd1);
    $display("timeout: flag=%0b op_a=%02h", timeout_flag, bus.op_a);

    // Freeze mid WAIT_B: timer must not advance while ena=0.
    send(8'h55, "frz a");
    idle(2, "frz wait");
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 8'h99, 1'b1, 1'b1);
      step();
      check_all("frz hold");
    end
    idle(1, "frz resume");
    send(8'h66, "frz b");
    check("frz pair valid", 32'(bus.op_valid), 32'd1);
    check("frz op_a", 32'(bus.op_a), 32'h55);
    check("frz op_b", 32'(bus.op_b), 32'h66);
    consume("frz consume");
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    check_all("clr");
    check("clr flag", 32'(timeout_flag), 32'd0);
    $display("freeze: pair a=55 b=66 done, flag=%0b", timeout_flag);

    // B arriving on the timeout cycle wins.
    send(8'h33, "race a");
    idle(3, "race wait");
    send(8'h44, "race b");
    check("race op_valid", 32'(bus.op_valid), 32'd1);
    check("race op_b", 32'(bus.op_b), 32'h44);
    check("race flag", 32'(timeout_flag), 32'd0);
    consume("race consume");
    $display("race: pair_count=%0d flag=%0b", pair_count, timeout_flag);

    // Asynchronous reset while a pair is presented.
    send(8'h77, "ar a");
    send(8'h88, "ar b");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("ar op_valid", 32'(bus.op_valid), 32'd0);
    check("ar op_a", 32'(bus.op_a), 32'd0);
    check("ar op_b", 32'(bus.op_b), 32'd0);
    check("ar pair_count", 32'(pair_count), 32'd0);
    check("ar flag", 32'(timeout_flag), 32'd0);
    check("ar in_ready", 32'(bus.in_ready), 32'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    send(8'hC3, "ar first");
    check("ar first capture", 32'(bus.op_a), 32'hC3);
    $display("async reset: first byte after release op_a=%02h", bus.op_a);

    // 256 pairs wrap the counter back to zero.
    send(8'h3D, "wrap b");
    consume("wrap consume");
    for (int i = 0; i < 255; i++) begin
      send(8'(i), "wrap a");
      send(8'(~i), "wrap b");
      consume("wrap consume");
      if (i == 253) check("wrap 255", 32'(pair_count), 32'd255);
    end
    check("wrap zero", 32'(pair_count), 32'd0);
    $display("wrap: pair_count=%0d after 256 pairs", pair_count);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 8) != 0, ($urandom % 3) != 0, 8'($urandom),
            ($urandom % 2) != 0, ($urandom % 10) == 0);
      if (ena && m_bytes == 2 && bus.op_ready)
        $display("rand pair: a=%02h b=%02h count=%0d", m_a, m_b, (m_pairs + 1) % 256);
      step();
      check_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
